// File: rtl/mul_div_ctrl_if.sv
// Handshake bundle between the EX stage (master) and the
// multiply/divide sequencer (slave).
interface mul_div_ctrl_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        ex_advance;
    logic        stallreq;
    logic [63:0] result;
    logic        result_valid;
    logic        busy;

    modport master (
        output start, op, opa, opb, flush, ex_advance,
        input  stallreq, result, result_valid, busy
    );

    modport slave (
        input  start, op, opa, opb, flush, ex_advance,
        output stallreq, result, result_valid, busy
    );
endinterface

// File: rtl/mul_div_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage.
// Multiply: product of the latched operands, registered after MUL_CYCLES.
// Divide: 32-iteration radix-2 restoring divider on operand magnitudes,
// with sign fixup on the final iteration. Result is {HI,LO}.
module mul_div_ctrl #(
    parameter int MUL_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    mul_div_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_MULT = 2'b00;

    state_t      state_q;
    logic [1:0]  op_q;
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic [4:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvsr_q;
    logic        quo_neg_q;
    logic        rem_neg_q;
    logic [63:0] result_q;
    logic        result_valid_q;
    logic        busy_q;

    // Magnitudes of the incoming operands; only signed DIV takes |x|.
    logic        in_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    // Operand magnitude for the divider, captured on acceptance
    always_comb begin
        in_signed = ~bus.op[0];
        abs_a     = (in_signed && bus.opa[31]) ? (32'd0 - bus.opa) : bus.opa;
        abs_b     = (in_signed && bus.opb[31]) ? (32'd0 - bus.opb) : bus.opb;
    end

    // Full 64-bit product: sign- or zero-extend to 64 bits, low 64 bits of
    // the product are then correct for both signed and unsigned operands.
    logic        mul_signed;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;

    // Product of the latched operands
    always_comb begin
        mul_signed = (op_q == OP_MULT);
        ext_a      = {{32{mul_signed & opa_q[31]}}, opa_q};
        ext_b      = {{32{mul_signed & opb_q[31]}}, opb_q};
        product    = ext_a * ext_b;
    end

    // One restoring-divide step. The partial remainder is always below the
    // divisor, so the shifted value fits 33 bits; a 34-bit subtract gives a
    // clean borrow bit.
    logic [32:0] shifted;
    logic [33:0] trial;
    logic        no_borrow;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Shift, trial-subtract, and sign fixup of the final iteration
    always_comb begin
        shifted   = {rem_q, quo_q[31]};
        trial     = {1'b0, shifted} - {2'b00, dvsr_q};
        no_borrow = ~trial[33];
        rem_next  = no_borrow ? trial[31:0] : shifted[31:0];
        quo_next  = {quo_q[30:0], no_borrow};
        quo_fix   = quo_neg_q ? (32'd0 - quo_next) : quo_next;
        rem_fix   = rem_neg_q ? (32'd0 - rem_next) : rem_next;
    end

    // Sequencer FSM with registered result, valid and busy
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            op_q           <= 2'b00;
            opa_q          <= 32'd0;
            opb_q          <= 32'd0;
            cnt_q          <= 5'd0;
            rem_q          <= 32'd0;
            quo_q          <= 32'd0;
            dvsr_q         <= 32'd0;
            quo_neg_q      <= 1'b0;
            rem_neg_q      <= 1'b0;
            result_q       <= 64'd0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else if (bus.flush) begin
            // Flush cancels whatever is in progress; result is left as-is.
            state_q        <= S_IDLE;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q  <= bus.op;
                        opa_q <= bus.opa;
                        opb_q <= bus.opb;
                        if (!bus.op[1]) begin
                            state_q <= S_MUL;
                            cnt_q   <= 5'(MUL_CYCLES - 1);
                            busy_q  <= 1'b1;
                        end else if (bus.opb == 32'd0) begin
                            // Divide by zero finishes immediately.
                            state_q        <= S_DONE;
                            result_q       <= {bus.opa, 32'hFFFF_FFFF};
                            result_valid_q <= 1'b1;
                        end else begin
                            state_q   <= S_DIV;
                            cnt_q     <= 5'd0;
                            busy_q    <= 1'b1;
                            rem_q     <= 32'd0;
                            quo_q     <= abs_a;
                            dvsr_q    <= abs_b;
                            quo_neg_q <= in_signed & (bus.opa[31] ^ bus.opb[31]);
                            rem_neg_q <= in_signed & bus.opa[31];
                        end
                    end
                end
                S_MUL: begin
                    if (!bus.start) begin
                        // EX dropped the request: abort like a flush.
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == 5'd0) begin
                        state_q        <= S_DONE;
                        result_q       <= product;
                        result_valid_q <= 1'b1;
                        busy_q         <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                S_DIV: begin
                    if (!bus.start) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q        <= S_DONE;
                            result_q       <= {rem_fix, quo_fix};
                            result_valid_q <= 1'b1;
                            busy_q         <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    // Hold the result until EX moves on; no new start here.
                    if (bus.ex_advance) begin
                        state_q        <= S_IDLE;
                        result_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.stallreq     = bus.start & ~bus.flush & (state_q != S_DONE);
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = busy_q;

endmodule

// File: doc/mul_div_ctrl.md
Name: mul_div_ctrl

Overview:
- Multi-cycle multiply/divide sequencer serving the EX stage; takes MULT/MULTU/DIV/DIVU requests and raises a stall request while busy.
- Returns a 64-bit {HI,LO} result on the EX stage's multiply/divide result input; EX writes HI/LO from it.
- Divide is a 32-iteration radix-2 restoring divider. Multiply is a registered product held for MUL_CYCLES cycles.
- Honours pipeline flush (exception) and EX-advance handshake.

Parameters:
- MUL_CYCLES, 1: cycles spent in MUL state (1..4); product available after them.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- start  in  1  EX holds a mult/div instruction; held high while EX stalled
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- opa  in  32  rs value (dividend / multiplicand)
- opb  in  32  rt value (divisor / multiplier)
- flush  in  1  pipeline flush; cancels any operation
- ex_advance  in  1  EX stage moves to MEM this cycle (pipeline not stalled)
- stallreq  out  1  to EX stallreq_from_div
- result  out  64  {HI,LO}; mult: product; div: {remainder, quotient}
- result_valid  out  1  result valid (DONE state)
- busy  out  1  state is MUL or DIV

Behaviour:
- States: IDLE, MUL, DIV, DONE. All outputs registered or decoded from state. On reset=0 at a clk edge: state IDLE, counters 0, result 0, result_valid 0, busy 0, stallreq 0.
- stallreq = start & ~flush & (state != DONE), combinational. All else registered.
- IDLE:
  - start=1, flush=0: latch op, opa, opb.
  - MULT/MULTU -> MUL, counter = MUL_CYCLES-1.
  - DIV/DIVU with opb != 0 -> DIV, counter 0.
  - DIV/DIVU with opb == 0 -> DONE directly, result = {opa, 32'hFFFFFFFF}.
- MUL:
  - Product formed from latched operands, signed for MULT, unsigned for MULTU; full 64 bits.
  - Counter decrements; at 0 -> DONE with result = product.
- DIV:
  - Signed DIV works on magnitudes |opa|, |opb|.
  - Per cycle: shift {rem,quo} left one bit, trial-subtract divisor, set quotient bit if no borrow.
  - After 32 iterations (counter 31) -> DONE.
  - Signed fixup: quotient negated if operand signs differ; remainder takes dividend's sign.
  - 0x80000000 / -1 yields quotient 0x80000000, remainder 0 (no trap).
- DONE:
  - result_valid=1, result held stable.
  - ex_advance=1 -> IDLE, result_valid 0 next cycle. A new start is not accepted in the same cycle.
- Latencies, counted from the first cycle start=1 in IDLE:
  - MULT: stallreq high 1+MUL_CYCLES cycles, then valid.
  - DIV: stallreq high 33 cycles, valid in cycle 34.
  - Divide-by-zero: stallreq high 1 cycle.
- Flush:
  - flush=1 in any state -> IDLE next edge, result_valid 0, result unchanged.
  - A start coinciding with flush is ignored.
- start falling while in MUL/DIV aborts the operation to IDLE, same as flush.
- Operand changes after acceptance are ignored.
- Back-to-back requests: after DONE->IDLE, a following mult/div with start=1 is accepted in that IDLE cycle.
- flush has priority over ex_advance. reset has priority over everything.

Test Plan:
- MULT opa=0xFFFFFFFD (-3), opb=5, MUL_CYCLES=1, ex_advance=0 until valid -> stallreq high 2 cycles; result=0xFFFFFFFF_FFFFFFF1, result_valid=1; ex_advance pulse -> IDLE.
- MULTU 0xFFFFFFFF x 2 -> result=0x00000001_FFFFFFFE; MULT with same operands -> 0xFFFFFFFF_FFFFFFFE.
- DIVU 100/7 -> stallreq high exactly 33 cycles; result HI=2, LO=14. DIV -7/2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV 0x1234/0 -> stallreq 1 cycle; result={0x00001234, 0xFFFFFFFF}.
- DIVU started, flush at DIV iteration 10 -> stallreq 0 and state IDLE next cycle, result_valid never set; then DIVU 9/3 completes with HI=0, LO=3.
- reset=0 mid-DIV at iteration 20 -> all outputs 0 after edge. Back-to-back MULTU then DIVU with ex_advance pulse between -> both results correct, second accepted the cycle after DONE.
